// File: rtl/multicycle_sequencer.sv
// Phase sequencer for a multi-cycle RV32I core: walks FETCH/DECODE/EXECUTE/MEM/WB,
// gates the architectural write enables, counts retirements and traps on faults.
module multicycle_sequencer #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  opcode_bits,
   input  logic        imem_ready,
   input  logic        dmem_ready,
   input  logic        halt,
   output logic        imem_req,
   output logic        ir_wen,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic        rf_wen,
   output logic        pc_wen,
   output logic [2:0]  state,
   output logic [31:0] instret,
   output logic        fault,
   output logic [1:0]  fault_code
);

   typedef enum logic [2:0] {
      S_FETCH   = 3'd0,
      S_DECODE  = 3'd1,
      S_EXECUTE = 3'd2,
      S_MEM     = 3'd3,
      S_WB      = 3'd4,
      S_HALT    = 3'd5,
      S_FAULT   = 3'd6
   } state_t;

   localparam logic [4:0] OP_R      = 5'b01100;
   localparam logic [4:0] OP_I      = 5'b00100;
   localparam logic [4:0] OP_LOAD   = 5'b00000;
   localparam logic [4:0] OP_STORE  = 5'b01000;
   localparam logic [4:0] OP_BRANCH = 5'b11000;
   localparam logic [4:0] OP_JAL    = 5'b11011;
   localparam logic [4:0] OP_JALR   = 5'b11001;
   localparam logic [4:0] OP_LUI    = 5'b01101;
   localparam logic [4:0] OP_AUIPC  = 5'b00101;

   // Last wait-count value at which a still-missing ready becomes a timeout.
   localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

   state_t     cur;
   logic [7:0] wait_cnt;
   logic       is_load;
   logic       is_store;
   logic       is_branch;
   logic       is_legal;
   state_t     retire_next;

   assign is_load     = (opcode_bits == OP_LOAD);
   assign is_store    = (opcode_bits == OP_STORE);
   assign is_branch   = (opcode_bits == OP_BRANCH);
   assign is_legal    = opcode_bits inside {OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH,
                                            OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};
   assign retire_next = halt ? S_HALT : S_FETCH;
   assign state       = cur;

   // Enables decode from the registered phase; ir_wen and the EXECUTE/MEM pc_wen
   // also look at same-cycle ready and class. Everything is masked while rst is high.
   always_comb begin
      // NOTE: every output gets a default first so no path through the case infers a latch.
      imem_req = 1'b0;
      ir_wen   = 1'b0;
      dmem_req = 1'b0;
      dmem_we  = 1'b0;
      rf_wen   = 1'b0;
      pc_wen   = 1'b0;
      if (!rst) begin
         unique case (cur)
            S_FETCH: begin
               imem_req = 1'b1;
               ir_wen   = imem_ready;
            end
            S_EXECUTE: pc_wen = is_branch;
            S_MEM: begin
               dmem_req = 1'b1;
               dmem_we  = is_store;
               pc_wen   = is_store & dmem_ready;
            end
            S_WB: begin
               rf_wen = 1'b1;
               pc_wen = 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state is updated with non-blocking assignments only.
      if (rst) begin
         cur        <= S_FETCH;
         instret    <= '0;
         fault      <= 1'b0;
         fault_code <= 2'b00;
         wait_cnt   <= '0;
      end else begin
         if (pc_wen) instret <= instret + 32'd1;
         // Every exit from FETCH/MEM changes state, so clearing here covers all changes.
         wait_cnt <= '0;
         unique case (cur)
            S_FETCH: begin
               if (imem_ready) begin
                  cur <= S_DECODE;
               end else if (wait_cnt == WAIT_LAST) begin
                  cur        <= S_FAULT;
                  fault      <= 1'b1;
                  fault_code <= 2'b10;
               end else begin
                  wait_cnt <= wait_cnt + 8'd1;
               end
            end
            S_DECODE: begin
               if (is_legal) begin
                  cur <= S_EXECUTE;
               end else begin
                  cur        <= S_FAULT;
                  fault      <= 1'b1;
                  fault_code <= 2'b01;
               end
            end
            S_EXECUTE: begin
               if (is_load || is_store) cur <= S_MEM;
               else if (is_branch)      cur <= retire_next;
               else                     cur <= S_WB;
            end
            S_MEM: begin
               if (dmem_ready) begin
                  cur <= is_store ? retire_next : S_WB;
               end else if (wait_cnt == WAIT_LAST) begin
                  cur        <= S_FAULT;
                  fault      <= 1'b1;
                  fault_code <= 2'b11;
               end else begin
                  wait_cnt <= wait_cnt + 8'd1;
               end
            end
            S_WB:    cur <= retire_next;
            S_HALT:  if (!halt) cur <= S_FETCH;
            S_FAULT: cur <= S_FAULT;
            default: cur <= S_FAULT;
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Randomized bench: an instruction-level model expands each instruction into its
// expected per-cycle phase/enable trace, which is driven and compared cycle by cycle.
module tb_multicycle_sequencer;

   localparam int unsigned TIMEOUT = 4;

   localparam logic [5:0] EN_IMEM = 6'b100000;
   localparam logic [5:0] EN_IR   = 6'b010000;
   localparam logic [5:0] EN_DREQ = 6'b001000;
   localparam logic [5:0] EN_WE   = 6'b000100;
   localparam logic [5:0] EN_RF   = 6'b000010;
   localparam logic [5:0] EN_PC   = 6'b000001;

   localparam logic [4:0] OP_R      = 5'b01100;
   localparam logic [4:0] OP_I      = 5'b00100;
   localparam logic [4:0] OP_LOAD   = 5'b00000;
   localparam logic [4:0] OP_STORE  = 5'b01000;
   localparam logic [4:0] OP_BRANCH = 5'b11000;
   localparam logic [4:0] OP_JAL    = 5'b11011;
   localparam logic [4:0] OP_JALR   = 5'b11001;
   localparam logic [4:0] OP_LUI    = 5'b01101;
   localparam logic [4:0] OP_AUIPC  = 5'b00101;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [4:0]  opcode_bits = '0;
   logic        imem_ready = 1'b0;
   logic        dmem_ready = 1'b0;
   logic        halt = 1'b0;
   logic        imem_req, ir_wen, dmem_req, dmem_we, rf_wen, pc_wen;
   logic [2:0]  state;
   logic [31:0] instret;
   logic        fault;
   logic [1:0]  fault_code;

   multicycle_sequencer #(.TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst), .opcode_bits(opcode_bits),
      .imem_ready(imem_ready), .dmem_ready(dmem_ready), .halt(halt),
      .imem_req(imem_req), .ir_wen(ir_wen), .dmem_req(dmem_req), .dmem_we(dmem_we),
      .rf_wen(rf_wen), .pc_wen(pc_wen), .state(state), .instret(instret),
      .fault(fault), .fault_code(fault_code)
   );

   always #5 clk = ~clk;

   // One expected clock cycle: inputs to drive and outputs required in that cycle.
   typedef struct {
      logic [2:0]  st;
      logic [5:0]  en;
      logic        ri;
      logic        rd;
      logic        h;
      logic [4:0]  op;
      logic [31:0] cnt;
      logic [1:0]  fc;
   } step_t;

   step_t       steps[$];
   logic [31:0] model_cnt = '0;
   logic [1:0]  cur_fc = 2'b00;
   int          n_tests = 0;
   int          n_fail  = 0;
   logic [4:0]  legal_ops [9] = '{OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH,
                                   OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
      end
   endtask

   function automatic logic rb();
      return 1'($urandom_range(0, 1));
   endfunction

   function automatic logic [4:0] rop();
      return 5'($urandom);
   endfunction

   function automatic bit legal_op(input logic [4:0] op);
      foreach (legal_ops[i]) if (legal_ops[i] == op) return 1'b1;
      return 1'b0;
   endfunction

   task automatic push(input int st, input logic [5:0] en, input logic ri, input logic rd,
                       input logic h, input logic [4:0] op);
      step_t s;
      s.st = 3'(st); s.en = en; s.ri = ri; s.rd = rd; s.h = h; s.op = op;
      s.cnt = model_cnt; s.fc = cur_fc;
      steps.push_back(s);
      if (en[0]) model_cnt = model_cnt + 32'd1;
   endtask

   // fw/mw = number of not-ready cycles before ready; >= TIMEOUT means ready never comes.
   task automatic build(input logic [4:0] op, input int fw, input int mw,
                        input bit hlt, input int hold);
      bit is_ld, is_st, is_br;
      is_ld = (op == OP_LOAD);
      is_st = (op == OP_STORE);
      is_br = (op == OP_BRANCH);
      for (int i = 0; i < fw && i < int'(TIMEOUT); i++) push(0, EN_IMEM, 1'b0, rb(), rb(), rop());
      if (fw >= int'(TIMEOUT)) begin cur_fc = 2'b10; return; end
      push(0, EN_IMEM | EN_IR, 1'b1, rb(), rb(), op);
      push(1, 6'b0, rb(), rb(), rb(), op);
      if (!legal_op(op)) begin cur_fc = 2'b01; return; end
      if (is_br) push(2, EN_PC, rb(), rb(), hlt, op);
      else       push(2, 6'b0, rb(), rb(), rb(), op);
      if (is_ld || is_st) begin
         for (int i = 0; i < mw && i < int'(TIMEOUT); i++)
            push(3, EN_DREQ | (is_st ? EN_WE : 6'b0), rb(), 1'b0, rb(), op);
         if (mw >= int'(TIMEOUT)) begin cur_fc = 2'b11; return; end
         if (is_st) push(3, EN_DREQ | EN_WE | EN_PC, rb(), 1'b1, hlt, op);
         else       push(3, EN_DREQ, rb(), 1'b1, rb(), op);
      end
      if (!is_br && !is_st) push(4, EN_RF | EN_PC, rb(), rb(), hlt, op);
      if (hlt) begin
         for (int i = 0; i < hold; i++) push(5, 6'b0, rb(), rb(), 1'b1, rop());
         push(5, 6'b0, rb(), rb(), 1'b0, rop());
      end
   endtask

   task automatic fault_tail();
      for (int i = 0; i < 3; i++) push(6, 6'b0, rb(), rb(), rb(), rop());
   endtask

   task automatic run_steps(input int limit);
      int n;
      step_t s;
      n = 0;
      while (steps.size() > 0 && n < limit) begin
         s = steps.pop_front();
         @(posedge clk); #1;
         rst = 1'b0; imem_ready = s.ri; dmem_ready = s.rd; halt = s.h; opcode_bits = s.op;
         @(negedge clk);
         check("state", 32'(state), 32'(s.st));
         check("enables", 32'({imem_req, ir_wen, dmem_req, dmem_we, rf_wen, pc_wen}), 32'(s.en));
         check("instret", instret, s.cnt);
         check("fault", 32'(fault), 32'(s.fc != 2'b00));
         check("fault_code", 32'(fault_code), 32'(s.fc));
         n++;
      end
      steps.delete();
   endtask

   // Holds rst for one cycle; the following step deasserts it after the reset edge.
   task automatic do_reset();
      @(posedge clk); #1;
      rst = 1'b1; halt = rb(); imem_ready = rb(); dmem_ready = rb();
      @(negedge clk);
      check("rst_enables", 32'({imem_req, ir_wen, dmem_req, dmem_we, rf_wen, pc_wen}), 32'd0);
      model_cnt = '0;
      cur_fc    = 2'b00;
      steps.delete();
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [4:0] op;
      int fw, mw, hold;
      bit hlt;

      do_reset();
      // R-type, back-to-back LOAD/STORE with 2 wait cycles, branch retiring into HALT.
      build(OP_R, 0, 0, 1'b0, 0);            run_steps(100);
      build(OP_LOAD, 0, 2, 1'b0, 0);         run_steps(100);
      build(OP_STORE, 0, 2, 1'b0, 0);        run_steps(100);
      build(OP_BRANCH, 0, 0, 1'b1, 4);       run_steps(100);

      // Illegal opcode traps, then reset clears.
      build(5'b11111, 0, 0, 1'b0, 0); fault_tail(); run_steps(100);
      do_reset();

      // Fetch timeout, fetch ready on the last allowed cycle, data timeout.
      build(OP_R, int'(TIMEOUT), 0, 1'b0, 0); fault_tail(); run_steps(100);
      do_reset();
      build(OP_R, int'(TIMEOUT) - 1, 0, 1'b0, 0); run_steps(100);
      build(OP_LOAD, 0, int'(TIMEOUT), 1'b0, 0); fault_tail(); run_steps(100);
      do_reset();

      // instret wrap: park in HALT, preload the counter, then retire twice.
      build(OP_BRANCH, 0, 0, 1'b1, 3); run_steps(4);
      force dut.instret = 32'hFFFF_FFFE;
      #1;
      release dut.instret;
      model_cnt = 32'hFFFF_FFFE;
      push(5, 6'b0, rb(), rb(), 1'b0, rop());
      build(OP_R, 0, 0, 1'b0, 0);
      build(OP_I, 0, 0, 1'b0, 0);
      build(OP_JAL, 0, 0, 1'b0, 0);
      run_steps(100);

      // Reset in the middle of a stalled MEM phase aborts without retiring.
      build(OP_LOAD, 0, 10, 1'b0, 0); run_steps(5);
      do_reset();

      for (int k = 0; k < 250; k++) begin
         op   = ($urandom_range(0, 9) == 0) ? rop() : legal_ops[$urandom_range(0, 8)];
         fw   = ($urandom_range(0, 15) == 0) ? int'(TIMEOUT) : int'($urandom_range(0, TIMEOUT - 1));
         mw   = ($urandom_range(0, 15) == 0) ? int'(TIMEOUT) : int'($urandom_range(0, TIMEOUT - 1));
         hlt  = ($urandom_range(0, 3) == 0);
         hold = int'($urandom_range(0, 3));
         build(op, fw, mw, hlt, hold);
         if (cur_fc != 2'b00) fault_tail();
         run_steps(1000);
         if (cur_fc != 2'b00) do_reset();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/multicycle_sequencer.md
# multicycle_sequencer

Phase sequencer that turns the single-cycle RV32I datapath into a multi-cycle machine sharing slow, handshaked instruction and data memories. It walks each instruction through FETCH, DECODE, EXECUTE, MEM and WB. It gates the architectural write enables (PC, instruction register, register file, data memory) so that the combinational control decoder's outputs take effect only in the correct phase. It also counts retired instructions, supports a halt request, and traps on illegal opcodes and memory timeouts.

## Interface
- TIMEOUT, 16: maximum cycles spent waiting for a memory ready in FETCH or MEM. Legal range 2..255.
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- opcode_bits  input  5  instruction[6:2] from the instruction register; stable from DECODE until the next ir_wen.
- imem_ready  input  1  instruction memory has data this cycle.
- dmem_ready  input  1  data memory access completes this cycle.
- halt  input  1  request to stop at the next retirement.
- imem_req  output  1  instruction fetch request.
- ir_wen  output  1  load the instruction register.
- dmem_req  output  1  data memory request.
- dmem_we  output  1  data memory write qualifier; replaces memRw directly.
- rf_wen  output  1  register file write enable.
- pc_wen  output  1  PC update; the datapath selects the target with pc_sel.
- state  output  3  FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WB=4, HALT=5, FAULT=6.
- instret  output  32  retired-instruction count.
- fault  output  1  sticky trap flag.
- fault_code  output  2  00 none, 01 illegal opcode, 10 imem timeout, 11 dmem timeout.

## Operation
- **Opcode classes (opcode_bits):**
  - R 01100, I 00100, LOAD 00000, STORE 01000, BRANCH 11000, JAL 11011, JALR 11001, LUI 01101, AUIPC 00101.
  - Any other value is illegal.
- **FETCH:**
  - imem_req=1.
  - imem_ready=1: ir_wen=1 in the same cycle; next state DECODE.
- **DECODE:** one cycle.
  - Illegal opcode: next FAULT with code 01.
  - Otherwise: next EXECUTE.
- **EXECUTE:** one cycle.
  - LOAD or STORE: next MEM.
  - BRANCH: pc_wen=1 (retire); next FETCH, or HALT.
  - All other classes: next WB.
- **MEM:**
  - dmem_req=1; dmem_we=1 only for STORE.
  - dmem_ready=1 and STORE: pc_wen=1 (retire); next FETCH or HALT.
  - dmem_ready=1 and LOAD: next WB.
- **WB:** one cycle; rf_wen=1 and pc_wen=1 (retire); next FETCH or HALT.
- **Retire:** any cycle with pc_wen=1.
  - instret increments by 1 and wraps from 0xFFFFFFFF to 0.
  - If halt=1 in the retire cycle, next state is HALT instead of FETCH.
- **HALT:**
  - All enables 0.
  - Returns to FETCH on the first cycle halt=0.
  - halt is ignored outside retire and HALT cycles.
- **Wait counter (8 bit):**
  - Cleared on every state change.
  - Increments each FETCH or MEM cycle in which ready=0.
  - If ready=0 while the counter equals TIMEOUT-1: next FAULT with code 10 (FETCH) or 11 (MEM).
  - A ready on that same cycle is accepted normally.
- **FAULT:**
  - fault=1; fault_code held.
  - All enables 0; instret frozen.
  - Exits only on rst.
- **Enable exclusivity:** ir_wen, rf_wen and dmem_req are never asserted in the same cycle. Outputs not named for a state are 0.

## Timing
- **Output decode:** Moore outputs decode from registered state. ir_wen and the MEM/EXECUTE pc_wen are Mealy on the ready inputs and class (same-cycle).
- **Reset:**
  - rst=1 on an edge sets state=FETCH, instret=0, fault=0, fault_code=00, wait counter=0.
  - During the reset cycle every enable output is 0, including imem_req.
  - The first imem_req is in the first cycle after rst deasserts.
  - rst mid-instruction aborts the instruction with no retire.
- **Cycles per instruction**, with ready=1 on the first request cycle:
  - BRANCH: 3.
  - STORE: 4.
  - R, I, JAL, JALR, LUI, AUIPC: 4.
  - LOAD: 5.
  - Each wait cycle adds 1.
- **Counter visibility:** instret shows the new value in the cycle after pc_wen.
- **Halt from HALT:** if halt drops in HALT, FETCH with imem_req=1 begins the next cycle.

## Test plan
- **Reset then R-type:** opcode 01100, imem_ready and dmem_ready tied 1 -> state sequence 0,1,2,4,0; rf_wen and pc_wen high only in the WB cycle; instret=1 after 4 cycles.
- **Load, then store with 3-cycle wait:**
  - LOAD (00000) with dmem_ready high on the 3rd MEM cycle -> dmem_we=0; WB follows; 7 cycles total.
  - STORE (01000) under the same wait -> dmem_we=1 for 3 cycles; pc_wen in the ready cycle; no rf_wen.
- **Branch retire with halt=1:** BRANCH (11000), halt=1 during EXECUTE -> pc_wen=1 in EXECUTE; state=5 next; hold 4 cycles with no requests; drop halt -> state 0 and imem_req=1 the next cycle.
- **Illegal opcode:** 11111 -> FAULT entered right after DECODE; fault_code=01; rf_wen and pc_wen never asserted; instret unchanged; rst clears.
- **Timeouts at TIMEOUT=4:**
  - imem_ready held 0 -> FAULT after exactly 4 FETCH cycles, code 10.
  - Repeat with ready on the 4th cycle -> no fault; DECODE follows.
  - dmem stall on LOAD -> code 11.
- **instret wrap and reset:** instret preloaded via 2^32-1 retirements (or forced) -> next retire gives 0; rst asserted mid-MEM -> instret=0 and FETCH, with no rf_wen.
